// File: rtl/ysyx_24100029_icache_pkg.sv
// Shared types and AXI constants for the direct-mapped instruction cache.
package ysyx_24100029_icache_pkg;

   localparam int unsigned DefNlines    = 16;
   localparam int unsigned DefLineWords = 4;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [2:0] SIZE_4B     = 3'b010;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StResp,
      StMissAr,
      StMissR,
      StMissResp
   } state_e;

endpackage

// File: rtl/ysyx_24100029_icache_array.sv
// Tag/valid/data storage: one combinational read port, per-beat word fill plus tag/valid write.
module ysyx_24100029_icache_array
   import ysyx_24100029_icache_pkg::*;
#(
   parameter int unsigned NLINES     = DefNlines,
   parameter int unsigned LINE_WORDS = DefLineWords,
   parameter int unsigned OffW       = $clog2(LINE_WORDS),
   parameter int unsigned IdxW       = $clog2(NLINES),
   parameter int unsigned TagW       = 32 - IdxW - OffW - 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [IdxW-1:0] rd_idx_i,
   input  logic [OffW-1:0] rd_off_i,
   output logic [TagW-1:0] rd_tag_o,
   output logic            rd_valid_o,
   output logic [31:0]     rd_word_o,
   input  logic            wr_word_en_i,
   input  logic [IdxW-1:0] wr_idx_i,
   input  logic [OffW-1:0] wr_off_i,
   input  logic [31:0]     wr_word_i,
   input  logic            wr_line_en_i,
   input  logic [TagW-1:0] wr_tag_i,
   input  logic            wr_valid_i,
   input  logic            inval_all_i
);

   logic [TagW-1:0]   tag_q  [NLINES];
   logic [31:0]       data_q [NLINES][LINE_WORDS];
   logic [NLINES-1:0] valid_q;

   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

   // Tag and data arrays are deliberately not reset; validity alone gates hits.
   always_ff @(posedge clk_i) begin
      if (wr_word_en_i) data_q[wr_idx_i][wr_off_i] <= wr_word_i;
      if (wr_line_en_i) tag_q[wr_idx_i] <= wr_tag_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else begin
         if (wr_line_en_i) valid_q[wr_idx_i] <= wr_valid_i;
         if (inval_all_i) valid_q <= '0;
      end
   end

endmodule

// File: rtl/ysyx_24100029_icache.sv
// Direct-mapped instruction cache: AXI-lite style fetch port, AXI4 burst refill port.
module ysyx_24100029_icache
   import ysyx_24100029_icache_pkg::*;
#(
   parameter int unsigned NLINES     = DefNlines,
   parameter int unsigned LINE_WORDS = DefLineWords
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        s_arvalid,
   output logic        s_arready,
   input  logic [31:0] s_araddr,
   output logic        s_rvalid,
   input  logic        s_rready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rlast,
   output logic [3:0]  s_rid,
   output logic        m_arvalid,
   input  logic        m_arready,
   output logic [31:0] m_araddr,
   output logic [3:0]  m_arid,
   output logic [7:0]  m_arlen,
   output logic [2:0]  m_arsize,
   output logic [1:0]  m_arburst,
   input  logic        m_rvalid,
   output logic        m_rready,
   input  logic [31:0] m_rdata,
   input  logic [1:0]  m_rresp,
   input  logic        m_rlast,
   input  logic        fence_i,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int unsigned OffW = $clog2(LINE_WORDS);
   localparam int unsigned IdxW = $clog2(NLINES);
   localparam int unsigned TagW = 32 - IdxW - OffW - 2;

   state_e          state_q;
   logic [TagW-1:0] req_tag_q;
   logic [IdxW-1:0] req_idx_q;
   logic [OffW-1:0] req_off_q;
   logic [OffW-1:0] cnt_q;
   logic            err_q, ovf_q, fence_pend_q;
   logic            s_arready_q, s_rvalid_q, m_arvalid_q, m_rready_q;
   logic [31:0]     s_rdata_q;
   logic [1:0]      s_rresp_q;
   logic [31:0]     hit_cnt_q, miss_cnt_q;

   logic [TagW-1:0] in_tag, rd_tag;
   logic [IdxW-1:0] in_idx;
   logic [OffW-1:0] in_off;
   logic            rd_valid, hit;
   logic [31:0]     rd_word;
   logic            beat, last_slot, beat_err, refill_err, ret_idle, inval_all;
   logic            wr_word_en, wr_line_en;
   logic            unused_byte_off;

   assign in_off          = s_araddr[OffW+1:2];
   assign in_idx          = s_araddr[OffW+IdxW+1:OffW+2];
   assign in_tag          = s_araddr[31:OffW+IdxW+2];
   assign unused_byte_off = ^s_araddr[1:0];

   assign hit = rd_valid && (rd_tag == in_tag) && !fence_i;

   // A beat is a protocol error if rlast disagrees with the last expected slot.
   assign beat       = (state_q == StMissR) && m_rvalid && m_rready_q;
   assign last_slot  = (cnt_q == OffW'(LINE_WORDS - 1)) && !ovf_q;
   assign beat_err   = (m_rresp != RESP_OKAY) || (m_rlast != last_slot);
   assign refill_err = err_q || beat_err;
   assign ret_idle   = ((state_q == StResp) || (state_q == StMissResp)) && s_rready;
   assign inval_all  = ((state_q == StIdle) && fence_i) || (ret_idle && (fence_pend_q || fence_i));
   assign wr_word_en = reset && beat && !ovf_q;
   assign wr_line_en = reset && beat && m_rlast;

   ysyx_24100029_icache_array #(
      .NLINES     (NLINES),
      .LINE_WORDS (LINE_WORDS)
   ) u_array (
      .clk_i        (clock),
      .rst_ni       (reset),
      .rd_idx_i     (in_idx),
      .rd_off_i     (in_off),
      .rd_tag_o     (rd_tag),
      .rd_valid_o   (rd_valid),
      .rd_word_o    (rd_word),
      .wr_word_en_i (wr_word_en),
      .wr_idx_i     (req_idx_q),
      .wr_off_i     (cnt_q),
      .wr_word_i    (m_rdata),
      .wr_line_en_i (wr_line_en),
      .wr_tag_i     (req_tag_q),
      .wr_valid_i   (!refill_err),
      .inval_all_i  (inval_all)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= StIdle;
         req_tag_q    <= '0;
         req_idx_q    <= '0;
         req_off_q    <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         ovf_q        <= 1'b0;
         fence_pend_q <= 1'b0;
         s_arready_q  <= 1'b0;
         s_rvalid_q   <= 1'b0;
         m_arvalid_q  <= 1'b0;
         m_rready_q   <= 1'b0;
         s_rdata_q    <= '0;
         s_rresp_q    <= RESP_OKAY;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               s_arready_q <= 1'b1;
               if (s_arvalid && s_arready_q) begin
                  s_arready_q <= 1'b0;
                  req_tag_q   <= in_tag;
                  req_idx_q   <= in_idx;
                  req_off_q   <= in_off;
                  if (hit) begin
                     state_q    <= StResp;
                     s_rvalid_q <= 1'b1;
                     s_rdata_q  <= rd_word;
                     s_rresp_q  <= RESP_OKAY;
                     hit_cnt_q  <= hit_cnt_q + 32'd1;
                  end else begin
                     state_q     <= StMissAr;
                     m_arvalid_q <= 1'b1;
                     miss_cnt_q  <= miss_cnt_q + 32'd1;
                     cnt_q       <= '0;
                     err_q       <= 1'b0;
                     ovf_q       <= 1'b0;
                  end
               end
            end
            StMissAr: begin
               if (m_arready) begin
                  m_arvalid_q <= 1'b0;
                  m_rready_q  <= 1'b1;
                  state_q     <= StMissR;
               end
            end
            StMissR: begin
               if (beat) begin
                  if (!ovf_q && (cnt_q == req_off_q)) s_rdata_q <= m_rdata;
                  if (last_slot && !m_rlast) ovf_q <= 1'b1;
                  if (!last_slot && !ovf_q) cnt_q <= cnt_q + OffW'(1);
                  err_q <= refill_err;
                  if (m_rlast) begin
                     m_rready_q <= 1'b0;
                     s_rvalid_q <= 1'b1;
                     s_rresp_q  <= refill_err ? RESP_SLVERR : RESP_OKAY;
                     state_q    <= StMissResp;
                  end
               end
            end
            StResp, StMissResp: begin
               if (s_rready) begin
                  s_rvalid_q  <= 1'b0;
                  s_arready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
         // Fences seen while busy wait until the response hands back to idle.
         if (ret_idle) fence_pend_q <= 1'b0;
         else if (fence_i && (state_q != StIdle)) fence_pend_q <= 1'b1;
      end
   end

   assign s_arready = s_arready_q;
   assign s_rvalid  = s_rvalid_q;
   assign s_rdata   = s_rdata_q;
   assign s_rresp   = s_rresp_q;
   assign s_rlast   = s_rvalid_q;
   assign s_rid     = 4'd0;
   assign m_arvalid = m_arvalid_q;
   assign m_araddr  = {req_tag_q, req_idx_q, {(OffW + 2){1'b0}}};
   assign m_arid    = 4'd0;
   assign m_arlen   = 8'(LINE_WORDS - 1);
   assign m_arsize  = SIZE_4B;
   assign m_arburst = BURST_INCR;
   assign m_rready  = m_rready_q;
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_24100029_icache.sv
// Scoreboard bench: fetch stimulus queues expected responses, a monitor pops on handshake.
module tb_ysyx_24100029_icache;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [31:0] s_araddr, s_rdata;
   logic [1:0]  s_rresp;
   logic [3:0]  s_rid, m_arid;
   logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
   logic [31:0] m_araddr, m_rdata;
   logic [7:0]  m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst, m_rresp;
   logic        fence_i;
   logic [31:0] hit_cnt, miss_cnt;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          issued = 0;
   int          resp_cnt = 0;
   int          ar_cnt = 0;
   int          nbeats = 4;
   int          err_beat = -1;
   logic [31:0] exp_araddr = '0;

   always #5 clock = ~clock;

   ysyx_24100029_icache dut (
      .clock     (clock),
      .reset     (reset),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_araddr  (s_araddr),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rlast   (s_rlast),
      .s_rid     (s_rid),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_araddr  (m_araddr),
      .m_arid    (m_arid),
      .m_arlen   (m_arlen),
      .m_arsize  (m_arsize),
      .m_arburst (m_arburst),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rlast   (m_rlast),
      .fence_i   (fence_i),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} + 32'h0101_0101;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_s_arready"}, s_arready, 0);
      chk({tag, "_s_rvalid"}, s_rvalid, 0);
      chk({tag, "_m_arvalid"}, m_arvalid, 0);
      chk({tag, "_m_rready"}, m_rready, 0);
      chk({tag, "_s_rdata"}, s_rdata, 0);
      chk({tag, "_s_rresp"}, s_rresp, 0);
      chk({tag, "_hit_cnt"}, hit_cnt, 0);
      chk({tag, "_miss_cnt"}, miss_cnt, 0);
   endtask

   // Downstream AXI4 memory: holds off arready two cycles, then bursts nbeats beats.
   initial begin
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      m_rresp   = 2'b00;
      m_rlast   = 1'b0;
      forever begin
         @(negedge clock);
         if (reset && m_arvalid === 1'b1) begin
            logic [31:0] a;
            int          i;
            a = m_araddr;
            chk("m_araddr", m_araddr, exp_araddr);
            chk("m_ar_fields", {m_arlen, m_arsize, m_arburst, m_arid},
                {8'd3, 3'b010, 2'b01, 4'd0});
            for (int d = 0; d < 2; d++) begin
               @(negedge clock);
               chk("m_arvalid_hold", m_arvalid, 1);
            end
            m_arready = 1'b1;
            ar_cnt++;
            @(negedge clock);
            m_arready = 1'b0;
            i = 0;
            while (i < nbeats && reset) begin
               m_rvalid = 1'b1;
               m_rdata  = mem_word(a + 32'(4 * i));
               m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
               m_rlast  = (i == nbeats - 1);
               if (m_rready) i++;
               @(negedge clock);
            end
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            m_rresp  = 2'b00;
         end
      end
   end

   // Monitor: pops one expectation per upstream read-data handshake.
   always @(negedge clock) begin
      if (reset && s_rvalid === 1'b1 && s_rready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got data %h with no expected entry", s_rdata);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("s_rdata", s_rdata, e.data);
            chk("s_rresp", s_rresp, e.resp);
            chk("s_rlast_rid", {s_rlast, s_rid}, 5'b10000);
         end
         resp_cnt++;
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                        input logic f);
      int n;
      @(negedge clock);
      s_arvalid = 1'b1;
      s_araddr  = a;
      exp_q.push_back('{data: d, resp: r});
      issued++;
      n = 0;
      while (!s_arready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("s_ar_accept", s_arready, 1);
      fence_i = f;
      @(negedge clock);
      s_arvalid = 1'b0;
      fence_i   = 1'b0;
   endtask

   task automatic wait_resp();
      int n;
      n = 0;
      while (resp_cnt < issued && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("resp_delivered", 32'(resp_cnt), 32'(issued));
   endtask

   task automatic wait_refill();
      int n;
      n = 0;
      while (!m_rready && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk("refill_started", m_rready, 1);
   endtask

   task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r,
                        input int miss, input logic f);
      int ar0;
      exp_araddr = {a[31:4], 4'h0};
      ar0 = ar_cnt;
      issue(a, d, r, f);
      wait_resp();
      chk("refill_issued", 32'(ar_cnt - ar0), 32'(miss));
   endtask

   initial begin
      int ar0;
      s_arvalid = 1'b0;
      s_araddr  = '0;
      s_rready  = 1'b1;
      fence_i   = 1'b0;

      repeat (3) @(negedge clock);
      check_zero("reset");
      reset = 1'b1;

      // Cold miss, then hit on the same line.
      fetch(32'h3000_0000, 32'h0101_3101, 2'b00, 1, 1'b0);
      chk("miss_cnt_cold", miss_cnt, 1);
      chk("hit_cnt_cold", hit_cnt, 0);
      ar0 = ar_cnt;
      issue(32'h3000_0008, 32'h0109_3101, 2'b00, 1'b0);
      chk("hit_latency", s_rvalid, 1);
      wait_resp();
      chk("hit_no_refill", 32'(ar_cnt - ar0), 0);
      chk("hit_cnt_1", hit_cnt, 1);

      // Conflict on index 0.
      fetch(32'h3000_0100, mem_word(32'h3000_0100), 2'b00, 1, 1'b0);
      fetch(32'h3000_0000, mem_word(32'h3000_0000), 2'b00, 1, 1'b0);
      chk("miss_cnt_conflict", miss_cnt, 3);

      // Errored beat, then early rlast; both leave the line invalid.
      err_beat = 1;
      fetch(32'h3000_0204, mem_word(32'h3000_0204), 2'b10, 1, 1'b0);
      err_beat = -1;
      fetch(32'h3000_0204, mem_word(32'h3000_0204), 2'b00, 1, 1'b0);
      nbeats = 3;
      fetch(32'h3000_0410, mem_word(32'h3000_0410), 2'b10, 1, 1'b0);
      nbeats = 4;
      fetch(32'h3000_0410, mem_word(32'h3000_0410), 2'b00, 1, 1'b0);
      chk("miss_cnt_err", miss_cnt, 7);

      // Fence during refill is deferred, then wipes everything.
      fetch(32'h3000_0020, mem_word(32'h3000_0020), 2'b00, 1, 1'b0);
      fetch(32'h3000_0024, mem_word(32'h3000_0024), 2'b00, 0, 1'b0);
      exp_araddr = 32'h3000_0530;
      ar0 = ar_cnt;
      issue(32'h3000_0530, mem_word(32'h3000_0530), 2'b00, 1'b0);
      wait_refill();
      fence_i = 1'b1;
      @(negedge clock);
      fence_i = 1'b0;
      wait_resp();
      chk("fence_refill", 32'(ar_cnt - ar0), 1);
      fetch(32'h3000_0530, mem_word(32'h3000_0530), 2'b00, 1, 1'b0);
      fetch(32'h3000_0020, mem_word(32'h3000_0020), 2'b00, 1, 1'b0);
      fetch(32'h3000_0530, mem_word(32'h3000_0530), 2'b00, 1, 1'b1);
      chk("miss_cnt_fence", miss_cnt, 12);
      chk("hit_cnt_fence", hit_cnt, 2);

      // Upstream back-pressure on a hit.
      s_rready = 1'b0;
      issue(32'h3000_0534, mem_word(32'h3000_0534), 2'b00, 1'b0);
      for (int k = 0; k < 5; k++) begin
         chk("stall_rvalid", s_rvalid, 1);
         chk("stall_rdata", s_rdata, mem_word(32'h3000_0534));
         chk("stall_arready", s_arready, 0);
         @(negedge clock);
      end
      s_rready = 1'b1;
      wait_resp();
      chk("hit_cnt_stall", hit_cnt, 3);

      // Reset in the middle of a refill.
      exp_araddr = 32'h3000_0640;
      issue(32'h3000_0640, mem_word(32'h3000_0640), 2'b00, 1'b0);
      wait_refill();
      reset = 1'b0;
      @(negedge clock);
      check_zero("mid_refill_reset");
      @(negedge clock);
      reset = 1'b1;
      exp_q.delete();
      issued = resp_cnt;
      fetch(32'h3000_0640, mem_word(32'h3000_0640), 2'b00, 1, 1'b0);
      chk("miss_cnt_after_reset", miss_cnt, 1);
      chk("hit_cnt_after_reset", hit_cnt, 0);

      repeat (2) @(negedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
